// File: rtl/dffre_pipe_pkg.sv
// Shared types and sizing helpers for the dffre_pipe_bank register chain.
// Mode encoding matches the i_Mode pin values directly.
package dffre_pipe_pkg;

  typedef enum logic [1:0] {
    MODE_SHIFT  = 2'b00,
    MODE_ROTATE = 2'b01,
    MODE_FLUSH  = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_t;

  // Width needed to hold an occupancy count in the range 0..depth inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dffre_stage.sv
// One pipeline stage: a WIDTH-bit data register plus its valid bit, sharing
// a synchronous active-high reset (highest priority) and a clock enable.
module dffre_stage #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             i_Reset,
  input  logic             i_Enable,
  input  logic [WIDTH-1:0] i_D,
  input  logic             i_Valid,
  output logic [WIDTH-1:0] o_Q,
  output logic             o_Valid
);

  always_ff @(posedge clk) begin
    if (i_Reset) begin
      o_Q     <= RESET_VAL;
      o_Valid <= 1'b0;
    end else if (i_Enable) begin
      o_Q     <= i_D;
      o_Valid <= i_Valid;
    end
  end

endmodule

// File: rtl/dffre_pipe_bank.sv
// DEPTH-stage enabled register pipeline with per-stage valid bits, an
// occupancy counter and SHIFT / ROTATE / FLUSH modes; mode 2'b11 holds.
module dffre_pipe_bank
  import dffre_pipe_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                          clk,
  input  logic                          i_Reset,
  input  logic                          i_Enable,
  input  logic [1:0]                    i_Mode,
  input  logic [WIDTH-1:0]              i_D,
  input  logic                          i_Valid,
  output logic [WIDTH-1:0]              o_Q,
  output logic                          o_Valid,
  output logic [count_width(DEPTH)-1:0] o_Count,
  output logic                          o_Full,
  output logic                          o_Empty
);

  localparam int            CW      = count_width(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  mode_t            mode;
  logic             stage_en;
  logic [WIDTH-1:0] s     [DEPTH];
  logic             v     [DEPTH];
  logic [WIDTH-1:0] d_in  [DEPTH];
  logic             v_in  [DEPTH];
  logic [WIDTH-1:0] head_d;
  logic             head_v;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;

  assign mode     = mode_t'(i_Mode);
  // The reserved mode gates the whole chain exactly like a low enable.
  assign stage_en = i_Enable && (mode != MODE_RSVD);

  // Source for stage 0; every other stage always takes its predecessor.
  always_comb begin
    head_d = RESET_VAL;
    head_v = 1'b0;
    case (mode)
      MODE_SHIFT: begin
        head_d = i_D;
        head_v = i_Valid;
      end
      MODE_ROTATE: begin
        head_d = s[DEPTH-1];
        head_v = v[DEPTH-1];
      end
      default: begin
        head_d = RESET_VAL;
        head_v = 1'b0;
      end
    endcase
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign d_in[k] = head_d;
      assign v_in[k] = head_v;
    end else begin : g_body
      assign d_in[k] = s[k-1];
      assign v_in[k] = v[k-1];
    end

    dffre_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk      (clk),
      .i_Reset  (i_Reset),
      .i_Enable (stage_en),
      .i_D      (d_in[k]),
      .i_Valid  (v_in[k]),
      .o_Q      (s[k]),
      .o_Valid  (v[k])
    );
  end

  // Modular CW-bit arithmetic: a transient +1 overflow is undone by the -1.
  always_comb begin
    cnt_nxt = cnt;
    case (mode)
      MODE_SHIFT: cnt_nxt = cnt + CW'(i_Valid) - CW'(v[DEPTH-1]);
      MODE_FLUSH: cnt_nxt = cnt - CW'(v[DEPTH-1]);
      default:    cnt_nxt = cnt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_Reset) begin
      cnt <= '0;
    end else if (stage_en) begin
      cnt <= cnt_nxt;
    end
  end

  assign o_Q     = s[DEPTH-1];
  assign o_Valid = v[DEPTH-1];
  assign o_Count = cnt;
  assign o_Full  = (cnt == DEPTH_C);
  assign o_Empty = (cnt == '0);

endmodule

// File: tb/tb_dffre_pipe_bank.sv
// Self-checking bench for dffre_pipe_bank (WIDTH=8, DEPTH=4, RESET_VAL=0):
// a reference model pushes expected outputs per cycle, compared after each edge.
module tb_dffre_pipe_bank;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int CW = 3;
  localparam int OW = W + 1 + CW + 2;

  logic          clk = 1'b0;
  logic          i_Reset = 1'b1;
  logic          i_Enable = 1'b0;
  logic [1:0]    i_Mode = 2'b00;
  logic [W-1:0]  i_D = '0;
  logic          i_Valid = 1'b0;
  logic [W-1:0]  o_Q;
  logic          o_Valid;
  logic [CW-1:0] o_Count;
  logic          o_Full;
  logic          o_Empty;

  logic [OW-1:0] exp_q[$];
  logic [OW-1:0] got;
  logic [OW-1:0] exp;
  int            n_tests = 0;
  int            n_fail  = 0;

  logic [W-1:0]  m_s[D];
  logic          m_v[D];
  int            m_cnt;

  dffre_pipe_bank #(.WIDTH(W), .DEPTH(D), .RESET_VAL(8'h00)) dut (
    .clk      (clk),
    .i_Reset  (i_Reset),
    .i_Enable (i_Enable),
    .i_Mode   (i_Mode),
    .i_D      (i_D),
    .i_Valid  (i_Valid),
    .o_Q      (o_Q),
    .o_Valid  (o_Valid),
    .o_Count  (o_Count),
    .o_Full   (o_Full),
    .o_Empty  (o_Empty)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  task automatic model_step(input logic rst, input logic en, input logic [1:0] mode,
                            input logic [W-1:0] d, input logic vld);
    logic [W-1:0] last_s;
    logic         last_v;
    if (rst) begin
      for (int k = 0; k < D; k++) begin
        m_s[k] = 8'h00;
        m_v[k] = 1'b0;
      end
      m_cnt = 0;
    end else if (en && mode != 2'b11) begin
      last_s = m_s[D-1];
      last_v = m_v[D-1];
      for (int k = D - 1; k > 0; k--) begin
        m_s[k] = m_s[k-1];
        m_v[k] = m_v[k-1];
      end
      if (mode == 2'b00) begin
        m_s[0] = d;
        m_v[0] = vld;
        m_cnt  = m_cnt + int'(vld) - int'(last_v);
      end else if (mode == 2'b01) begin
        m_s[0] = last_s;
        m_v[0] = last_v;
      end else begin
        m_s[0] = 8'h00;
        m_v[0] = 1'b0;
        m_cnt  = m_cnt - int'(last_v);
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive_cycle(input logic rst, input logic en, input logic [1:0] mode,
                             input logic [W-1:0] d, input logic vld);
    i_Reset  = rst;
    i_Enable = en;
    i_Mode   = mode;
    i_D      = d;
    i_Valid  = vld;
    model_step(rst, en, mode, d, vld);
    exp_q.push_back({m_s[D-1], m_v[D-1], CW'(m_cnt), m_cnt == D, m_cnt == 0});
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive_cycle(1'b1, 1'b1, 2'b00, 8'hFF, 1'b1);
      got = {o_Q, o_Valid, o_Count, o_Full, o_Empty};
      exp = exp_q.pop_front();
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL reset_sb cycle %0d: got %h expected %h", i, got, exp);
      end
    end
    n_tests++;
    if (o_Q !== 8'h00 || o_Valid !== 1'b0 || o_Count !== 3'd0 || o_Empty !== 1'b1 || o_Full !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: q=%h v=%b cnt=%0d empty=%b full=%b expected q=00 v=0 cnt=0 empty=1 full=0",
               o_Q, o_Valid, o_Count, o_Empty, o_Full);
    end
  endtask

  task automatic test_shift_fill();
    logic [W-1:0] vals[5];
    vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    for (int i = 0; i < 5; i++) begin
      drive_cycle(1'b0, 1'b1, 2'b00, vals[i], 1'b1);
      got = {o_Q, o_Valid, o_Count, o_Full, o_Empty};
      exp = exp_q.pop_front();
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL shift_fill_sb step %0d: got %h expected %h", i, got, exp);
      end
      n_tests++;
      if (o_Count !== CW'(i < 4 ? i + 1 : 4)) begin
        n_fail++;
        $display("FAIL shift_fill_count step %0d: got %0d expected %0d", i, o_Count, (i < 4 ? i + 1 : 4));
      end
    end
    n_tests++;
    if (o_Q !== 8'h22 || o_Valid !== 1'b1 || o_Full !== 1'b1) begin
      n_fail++;
      $display("FAIL shift_fifth: q=%h v=%b full=%b expected q=22 v=1 full=1", o_Q, o_Valid, o_Full);
    end
  endtask

  task automatic test_enable_low();
    for (int i = 0; i < 6; i++) begin
      // First three cycles disable; last three use the reserved mode with enable high.
      if (i < 3) drive_cycle(1'b0, 1'b0, 2'b00, (i % 2 == 0) ? 8'hA5 : 8'h5A, 1'b1);
      else       drive_cycle(1'b0, 1'b1, 2'b11, 8'hC3, 1'b1);
      got = {o_Q, o_Valid, o_Count, o_Full, o_Empty};
      exp = exp_q.pop_front();
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL hold_sb cycle %0d: got %h expected %h", i, got, exp);
      end
      n_tests++;
      if (o_Q !== 8'h22 || o_Valid !== 1'b1 || o_Count !== 3'd4) begin
        n_fail++;
        $display("FAIL hold_state cycle %0d: q=%h v=%b cnt=%0d expected q=22 v=1 cnt=4", i, o_Q, o_Valid, o_Count);
      end
    end
  endtask

  task automatic test_rotate();
    logic [W-1:0] fill[4];
    logic [W-1:0] rot_exp[4];
    fill    = '{8'h11, 8'h22, 8'h33, 8'h44};
    rot_exp = '{8'h22, 8'h33, 8'h44, 8'h11};
    for (int i = 0; i < 9; i++) begin
      if (i == 0)     drive_cycle(1'b1, 1'b0, 2'b00, 8'h00, 1'b0);
      else if (i < 5) drive_cycle(1'b0, 1'b1, 2'b00, fill[i-1], 1'b1);
      else            drive_cycle(1'b0, 1'b1, 2'b01, 8'hEE, 1'b0);
      got = {o_Q, o_Valid, o_Count, o_Full, o_Empty};
      exp = exp_q.pop_front();
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL rotate_sb cycle %0d: got %h expected %h", i, got, exp);
      end
      if (i >= 5) begin
        n_tests++;
        if (o_Q !== rot_exp[i-5] || o_Count !== 3'd4) begin
          n_fail++;
          $display("FAIL rotate_q step %0d: q=%h cnt=%0d expected q=%h cnt=4", i - 5, o_Q, o_Count, rot_exp[i-5]);
        end
      end
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b0, 1'b1, 2'b10, 8'hAA, 1'b1);
      got = {o_Q, o_Valid, o_Count, o_Full, o_Empty};
      exp = exp_q.pop_front();
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL flush_sb step %0d: got %h expected %h", i, got, exp);
      end
      n_tests++;
      if (o_Count !== CW'(3 - i)) begin
        n_fail++;
        $display("FAIL flush_count step %0d: got %0d expected %0d", i, o_Count, 3 - i);
      end
    end
    n_tests++;
    if (o_Empty !== 1'b1 || o_Q !== 8'h00 || o_Valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_final: empty=%b q=%h v=%b expected empty=1 q=00 v=0", o_Empty, o_Q, o_Valid);
    end
  endtask

  task automatic test_reset_priority();
    for (int i = 0; i < 4; i++) begin
      if (i < 3) drive_cycle(1'b0, 1'b1, 2'b00, 8'h70 + 8'(i), 1'b1);
      else       drive_cycle(1'b1, 1'b1, 2'b01, 8'hFF, 1'b1);
      got = {o_Q, o_Valid, o_Count, o_Full, o_Empty};
      exp = exp_q.pop_front();
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL rst_prio_sb cycle %0d: got %h expected %h", i, got, exp);
      end
      if (i == 2) begin
        n_tests++;
        if (o_Count !== 3'd3) begin
          n_fail++;
          $display("FAIL rst_prio_pre: cnt=%0d expected 3", o_Count);
        end
      end
    end
    n_tests++;
    if (o_Count !== 3'd0 || o_Q !== 8'h00 || o_Empty !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_prio_post: cnt=%0d q=%h empty=%b expected cnt=0 q=00 empty=1", o_Count, o_Q, o_Empty);
    end
  endtask

  task automatic test_random();
    logic       rst;
    logic       en;
    logic [1:0] mode;
    for (int i = 0; i < 1000; i++) begin
      rst  = ($urandom_range(0, 49) == 0);
      en   = ($urandom_range(0, 3) != 0);
      mode = 2'($urandom_range(0, 3));
      drive_cycle(rst, en, mode, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      got = {o_Q, o_Valid, o_Count, o_Full, o_Empty};
      exp = exp_q.pop_front();
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL random_sb cycle %0d: got %h expected %h", i, got, exp);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int k = 0; k < D; k++) begin
      m_s[k] = 8'h00;
      m_v[k] = 1'b0;
    end
    m_cnt = 0;
    @(posedge clk);
    #1;
    test_reset();
    test_shift_fill();
    test_enable_low();
    test_rotate();
    test_flush();
    test_reset_priority();
    test_random();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
